// File: rtl/led_ws2812_chain.sv
// WS2812 (Neopixel) chain driver.
// Fetches each LED colour through a request/response handshake, serialises it as
// 24 GRB bits (MSB first) with WS2812 pulse timing, then holds the line low for the
// latch gap. Refreshes the chain continuously while enable_i is high.
//
// Ports:
//   clk_i                 system clock (50MHz)
//   reset_ni              asynchronous active-low reset
//   enable_i              high: refresh the chain continuously
//   led_data_valid_i      one-cycle colour response strobe
//   led_data_red_i        red byte for the requested LED
//   led_data_green_i      green byte for the requested LED
//   led_data_blue_i       blue byte for the requested LED
//   led_request_valid_o   colour request outstanding
//   led_request_number_o  index of the requested LED
//   led_request_last_o    requested LED is the last one in the chain
//   led_chain_o           serial data, active high
//   frame_done_o          one-cycle pulse on the final cycle of the latch gap
module led_ws2812_chain #(
   parameter int unsigned NumLeds     = 8,
   parameter int unsigned BitCycles   = 63,
   parameter int unsigned T0hCycles   = 18,
   parameter int unsigned T1hCycles   = 35,
   parameter int unsigned ResetCycles = 3000
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       enable_i,
   input  logic       led_data_valid_i,
   input  logic [7:0] led_data_red_i,
   input  logic [7:0] led_data_green_i,
   input  logic [7:0] led_data_blue_i,
   output logic       led_request_valid_o,
   output logic [7:0] led_request_number_o,
   output logic       led_request_last_o,
   output logic       led_chain_o,
   output logic       frame_done_o
);

   typedef enum logic [1:0] {StIdle, StRequest, StSend, StGap} state_e;

   localparam logic [15:0] BitLast = 16'(BitCycles - 1);
   localparam logic [15:0] GapLast = 16'(ResetCycles - 1);
   localparam logic [15:0] T0h     = 16'(T0hCycles);
   localparam logic [15:0] T1h     = 16'(T1hCycles);
   localparam logic [7:0]  LedLast = 8'(NumLeds - 1);

   state_e      state_q, state_d;
   logic        req_valid_q, req_valid_d;
   logic [7:0]  req_num_q, req_num_d;
   logic [23:0] shift_q, shift_d;
   logic [4:0]  bit_idx_q, bit_idx_d;
   logic [15:0] cnt_q, cnt_d;
   logic        chain_q, chain_d;

   always_comb begin
      state_d     = state_q;
      req_valid_d = req_valid_q;
      req_num_d   = req_num_q;
      shift_d     = shift_q;
      bit_idx_d   = bit_idx_q;
      cnt_d       = cnt_q;

      unique case (state_q)
         StIdle: begin
            if (enable_i) begin
               req_num_d   = 8'd0;
               req_valid_d = 1'b1;
               state_d     = StRequest;
            end
         end
         StRequest: begin
            if (led_data_valid_i) begin
               shift_d     = {led_data_green_i, led_data_red_i, led_data_blue_i};
               bit_idx_d   = 5'd0;
               cnt_d       = 16'd0;
               req_valid_d = 1'b0;
               state_d     = StSend;
            end
         end
         StSend: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == BitLast) begin
               cnt_d = 16'd0;
               if (bit_idx_q == 5'd23) begin
                  if (req_num_q < LedLast) begin
                     req_num_d   = req_num_q + 8'd1;
                     req_valid_d = 1'b1;
                     state_d     = StRequest;
                  end else begin
                     state_d = StGap;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 5'd1;
                  shift_d   = {shift_q[22:0], 1'b0};
               end
            end
         end
         StGap: begin
            cnt_d = cnt_q + 16'd1;
            if (cnt_q == GapLast) begin
               cnt_d   = 16'd0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      // Output registered from next-state values so the line is glitch-free and aligned
      // with the bit counter.
      chain_d = (state_d == StSend) && (cnt_d < (shift_d[23] ? T1h : T0h));
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= StIdle;
         req_valid_q <= 1'b0;
         req_num_q   <= 8'd0;
         shift_q     <= 24'd0;
         bit_idx_q   <= 5'd0;
         cnt_q       <= 16'd0;
         chain_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_valid_q <= req_valid_d;
         req_num_q   <= req_num_d;
         shift_q     <= shift_d;
         bit_idx_q   <= bit_idx_d;
         cnt_q       <= cnt_d;
         chain_q     <= chain_d;
      end
   end

   assign led_request_valid_o  = req_valid_q;
   assign led_request_number_o = req_num_q;
   assign led_request_last_o   = (req_num_q == LedLast);
   assign led_chain_o          = chain_q;
   assign frame_done_o         = (state_q == StGap) && (cnt_q == GapLast);

endmodule

// File: tb/tb_led_ws2812_chain.sv
// Self-checking bench for led_ws2812_chain: a randomised colour responder plus a
// waveform decoder that measures pulse widths on led_chain and compares them with
// the colours handed out.
module tb_led_ws2812_chain;

   localparam int NumLeds     = 4;
   localparam int BitCycles   = 63;
   localparam int T0h         = 18;
   localparam int T1h         = 35;
   localparam int ResetCycles = 3000;
   localparam int LedCycles   = 24 * BitCycles;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       enable = 1'b0;
   logic       dv = 1'b0;
   logic [7:0] red = 8'd0, green = 8'd0, blue = 8'd0;
   logic       req_valid, req_last, chain, frame_done;
   logic [7:0] req_num;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   led_ws2812_chain #(
      .NumLeds    (NumLeds),
      .BitCycles  (BitCycles),
      .T0hCycles  (T0h),
      .T1hCycles  (T1h),
      .ResetCycles(ResetCycles)
   ) dut (
      .clk_i               (clk),
      .reset_ni            (reset_n),
      .enable_i            (enable),
      .led_data_valid_i    (dv),
      .led_data_red_i      (red),
      .led_data_green_i    (green),
      .led_data_blue_i     (blue),
      .led_request_valid_o (req_valid),
      .led_request_number_o(req_num),
      .led_request_last_o  (req_last),
      .led_chain_o         (chain),
      .frame_done_o        (frame_done)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   // Responder: answers each request after a chosen delay with a random colour,
   // and throws spurious strobes at the DUT while no request is outstanding.
   logic [23:0] colours [NumLeds];
   int delay_mode  = -1;
   int slow_led    = -1;
   bit spurious_en = 1'b1;
   bit answered    = 1'b0;
   bit saw_high    = 1'b0;
   int waited      = 0;
   int my_delay    = 0;
   int exp_num     = 0;

   always @(negedge clk) begin
      dv = 1'b0;
      if (!reset_n) begin
         answered = 1'b0;
         waited   = 0;
         exp_num  = 0;
      end else if (req_valid && !answered) begin
         if (waited == 0) begin
            check_eq("req_num", req_num, exp_num);
            check_eq("req_last", req_last, exp_num == NumLeds - 1);
            if (exp_num == slow_led) my_delay = 200;
            else if (delay_mode >= 0) my_delay = delay_mode;
            else my_delay = $urandom_range(0, 5);
            saw_high = 1'b0;
         end
         if (chain) saw_high = 1'b1;
         if (waited == my_delay) begin
            colours[exp_num] = 24'($urandom);
            {green, red, blue} = colours[exp_num];
            dv       = 1'b1;
            answered = 1'b1;
            check_eq("wait_low", saw_high, 0);
            exp_num  = (exp_num + 1) % NumLeds;
         end
         waited++;
      end else begin
         if (!req_valid) begin
            if (!answered && waited > 0) check_eq("req_held", req_valid, 1);
            answered = 1'b0;
            waited   = 0;
            if (spurious_en && $urandom_range(0, 40) == 0) begin
               {green, red, blue} = 24'($urandom);
               dv = 1'b1;
            end
         end
      end
   end

   // Decoder: every high pulse must match the expected bit of the colour stream.
   int   bit_cnt  = 0;
   int   rise_cyc = 0;
   int   frames   = 0;
   logic prev     = 1'b0;
   int   fd_cyc[$];

   always @(negedge clk) begin : mon
      int led;
      if (!reset_n) begin
         bit_cnt = 0;
         prev    = 1'b0;
      end else begin
         if (chain && !prev) begin
            if (bit_cnt % 24 != 0) check_eq("period", cyc - rise_cyc, BitCycles);
            rise_cyc = cyc;
         end
         if (!chain && prev) begin
            led = (bit_cnt / 24) % NumLeds;
            check_eq("high_time", cyc - rise_cyc,
                     colours[led][23 - bit_cnt % 24] ? T1h : T0h);
            bit_cnt++;
         end
         if (frame_done) begin
            check_eq("gap", cyc - rise_cyc, BitCycles + ResetCycles - 1);
            check_eq("bits", bit_cnt, 24 * NumLeds);
            bit_cnt = 0;
            frames++;
            fd_cyc.push_back(cyc);
         end
         prev = chain;
      end
   end

   task automatic wait_frames(input int target, input int budget);
      int n = 0;
      while (frames < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq("frame_count", frames, target);
   endtask

   task automatic pulse_enable();
      @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      enable = 1'b0;
   endtask

   initial begin
      int n;
      int frame_len;
      repeat (3) @(negedge clk);
      check_eq("rst_chain", chain, 0);
      check_eq("rst_req_valid", req_valid, 0);
      check_eq("rst_req_num", req_num, 0);
      check_eq("rst_frame_done", frame_done, 0);
      check_eq("rst_req_last", req_last, 0);
      reset_n = 1'b1;

      // Single frame, random response delays, LED 2 answered after 200 cycles.
      slow_led = 2;
      pulse_enable();
      wait_frames(1, 12000);
      repeat (100) @(negedge clk);
      check_eq("idle_after_single", req_valid, 0);
      check_eq("single_frame_only", frames, 1);

      // Continuous refresh with a fixed delay; drop enable partway through frame 3.
      slow_led   = -1;
      delay_mode = 2;
      enable     = 1'b1;
      wait_frames(3, 20000);
      repeat (1000) @(negedge clk);
      enable = 1'b0;
      wait_frames(4, 10000);
      frame_len = 1 + NumLeds * (delay_mode + 1 + LedCycles) + ResetCycles;
      check_eq("fd_count", fd_cyc.size(), 4);
      if (fd_cyc.size() >= 4) begin
         check_eq("frame_len_a", fd_cyc[2] - fd_cyc[1], frame_len);
         check_eq("frame_len_b", fd_cyc[3] - fd_cyc[2], frame_len);
      end
      repeat (500) @(negedge clk);
      check_eq("idle_after_stop", req_valid, 0);
      check_eq("no_extra_frame", frames, 4);

      // Reset in the middle of a high pulse of LED 1.
      delay_mode = -1;
      pulse_enable();
      n = 0;
      while (!(req_num == 8'd1 && chain && !req_valid) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check_eq("reach_led1", n < 5000, 1);
      #3 reset_n = 1'b0;
      #1;
      check_eq("async_chain", chain, 0);
      check_eq("async_req_num", req_num, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      check_eq("idle_after_reset", req_valid, 0);
      pulse_enable();
      wait_frames(5, 12000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
